// File: rtl/unshuffle_pkg.sv
// Shared constants, FSM encoding and pixel-to-word mapping for the unshuffle
// reader/writer pair and their benches.
package unshuffle_pkg;

    localparam int IMG_W           = 28;
    localparam int BW_PER_ACT      = 12;
    localparam int CH_NUM          = 4;
    localparam int ACT_PER_ADDR    = 4;
    localparam int ADDR_ROW_STRIDE = 4;
    localparam int NUM_ACT         = CH_NUM * ACT_PER_ADDR;
    localparam int WORD_BW         = NUM_ACT * BW_PER_ACT;
    localparam int ADDR_W          = 6;
    localparam int ROW_W           = $clog2(IMG_W);
    localparam int BCOL_W          = $clog2(IMG_W / 4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic [WORD_BW-1:0] data;
        logic [1:0]         ir;
        logic               last;
    } fifo_entry_t;

    // Bank is {block-row parity, block-column parity}.
    function automatic logic [1:0] pix_bank(input int r, input int c);
        return 2'(((r / 4) % 2) * 2 + ((c / 4) % 2));
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(input int r, input int c);
        return ADDR_W'((r / 8) * ADDR_ROW_STRIDE + (c / 8));
    endfunction

    // Activation index inside a word: ch*4 + pos.
    function automatic logic [3:0] pix_index(input int ir, input int ic);
        return 4'(((ir % 2) * 2 + (ic % 2)) * 4 + (ir / 2) * 2 + (ic / 2));
    endfunction

    // Activations are packed MSB-first: index 0 sits in the top 12 bits.
    function automatic logic [BW_PER_ACT-1:0] word_act(input logic [WORD_BW-1:0] word,
                                                       input int idx);
        return word[(NUM_ACT - 1 - idx) * BW_PER_ACT +: BW_PER_ACT];
    endfunction

endpackage

// File: rtl/unshuffle_word_fifo.sv
// Two-entry word FIFO holding captured SRAM words with their local row and last flag.
module unshuffle_word_fifo
    import unshuffle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_ent,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [1:0]  count
);

    fifo_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_ent;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/unshuffle_reader.sv
// Reads the pixel-unshuffled image from SRAM group A and streams it out in raster order.
// Optional UNSHUFFLE_READER_RELU_EN clamps negative pixels to zero.
module unshuffle_reader
    import unshuffle_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     sram_raddr_a0,
    output logic [ADDR_W-1:0]     sram_raddr_a1,
    output logic [ADDR_W-1:0]     sram_raddr_a2,
    output logic [ADDR_W-1:0]     sram_raddr_a3,
    input  logic [WORD_BW-1:0]    sram_rdata_a0,
    input  logic [WORD_BW-1:0]    sram_rdata_a1,
    input  logic [WORD_BW-1:0]    sram_rdata_a2,
    input  logic [WORD_BW-1:0]    sram_rdata_a3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BW_PER_ACT-1:0] out_data,
    output logic                  out_last
);

    logic [1:0]               state;
    logic [ROW_W-1:0]         row;
    logic [BCOL_W-1:0]        bcol;
    logic [3:0][ADDR_W-1:0]   raddr_q;
    logic [3:0][ADDR_W-1:0]   raddr;
    logic [3:0][WORD_BW-1:0]  rdata;
    logic                     rd_vld;
    logic [1:0]               rd_bank;
    logic [1:0]               rd_ir;
    logic                     rd_last;
    logic [1:0]               ic;
    logic [1:0]               fifo_cnt;
    fifo_entry_t              push_ent;
    fifo_entry_t              head;
    logic                     issue;
    logic                     last_word;
    logic                     row_end;
    logic                     hs;
    logic                     pop;
    logic [1:0]               iss_bank;
    logic [ADDR_W-1:0]        iss_addr;
    logic [BW_PER_ACT-1:0]    pix;
    logic [BW_PER_ACT-1:0]    pix_out;

    assign row_end   = (bcol == BCOL_W'(IMG_W / 4 - 1));
    assign last_word = row_end && (row == ROW_W'(IMG_W - 1));
    // In-flight read counts against FIFO space so a capture never overflows.
    assign issue     = (state == S_RUN) && ((fifo_cnt + 2'(rd_vld)) < 2'd2);
    assign iss_bank  = pix_bank(int'(row), int'({bcol, 2'b00}));
    assign iss_addr  = pix_addr(int'(row), int'({bcol, 2'b00}));

    // The new address is presented in the issue cycle; other banks hold.
    always_comb begin
        raddr = raddr_q;
        if (issue)
            raddr[iss_bank] = iss_addr;
    end

    assign sram_raddr_a0 = raddr[0];
    assign sram_raddr_a1 = raddr[1];
    assign sram_raddr_a2 = raddr[2];
    assign sram_raddr_a3 = raddr[3];
    assign rdata = {sram_rdata_a3, sram_rdata_a2, sram_rdata_a1, sram_rdata_a0};

    always_comb begin
        push_ent      = '0;
        push_ent.data = rdata[rd_bank];
        push_ent.ir   = rd_ir;
        push_ent.last = rd_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            row     <= '0;
            bcol    <= '0;
            raddr_q <= '0;
            rd_vld  <= 1'b0;
            rd_bank <= '0;
            rd_ir   <= '0;
            rd_last <= 1'b0;
            ic      <= '0;
        end else begin
            rd_vld <= issue;
            if (issue) begin
                raddr_q[iss_bank] <= iss_addr;
                rd_bank           <= iss_bank;
                rd_ir             <= row[1:0];
                rd_last           <= last_word;
                if (row_end) begin
                    bcol <= '0;
                    row  <= row + 1'b1;
                end else begin
                    bcol <= bcol + 1'b1;
                end
            end
            if (hs)
                ic <= ic + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_RUN;
                    row   <= '0;
                    bcol  <= '0;
                end
                S_RUN:   if (issue && last_word) state <= S_DRAIN;
                S_DRAIN: if (hs && out_last)     state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    unshuffle_word_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_vld),
        .push_ent (push_ent),
        .pop      (pop),
        .head     (head),
        .count    (fifo_cnt)
    );

    assign out_valid = (fifo_cnt != 2'd0);
    assign hs        = out_valid && out_ready;
    assign pop       = hs && (ic == 2'd3);
    assign pix       = word_act(head.data, int'(pix_index(int'(head.ir), int'(ic))));

`ifdef UNSHUFFLE_READER_RELU_EN
    assign pix_out = pix[BW_PER_ACT-1] ? '0 : pix;
`else
    assign pix_out = pix;
`endif

    assign out_data = out_valid ? pix_out : '0;
    assign out_last = out_valid && head.last && (ic == 2'd3);
    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_unshuffle_reader.sv
// Directed bench for unshuffle_reader: SRAM model filled by a local writer model.
module tb_unshuffle_reader;

    logic         clk = 1'b0;
    logic         rst, start, busy, done;
    logic [5:0]   sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3;
    logic [191:0] sram_rdata_a0, sram_rdata_a1, sram_rdata_a2, sram_rdata_a3;
    logic         out_valid, out_ready, out_last;
    logic [11:0]  out_data;

    int errors = 0;
    int checks = 0;

    logic [191:0] mem [4][64];
    logic [11:0]  pix [$];
    int           rec_bank [$];
    int           rec_addr [$];
    bit           rec_en = 1'b0;
    logic [5:0]   prev_addr [4];

    int npix, first_vld, last_cnt, last_idx, last_cyc, done_cnt, done_cyc, stall_viol;
    bit busy1, busy_after, timeout;

    always #5 clk = ~clk;

    unshuffle_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .sram_raddr_a0(sram_raddr_a0), .sram_raddr_a1(sram_raddr_a1),
        .sram_raddr_a2(sram_raddr_a2), .sram_raddr_a3(sram_raddr_a3),
        .sram_rdata_a0(sram_rdata_a0), .sram_rdata_a1(sram_rdata_a1),
        .sram_rdata_a2(sram_rdata_a2), .sram_rdata_a3(sram_rdata_a3),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    // Synchronous SRAM: data one cycle after the address.
    always @(posedge clk) begin
        sram_rdata_a0 <= mem[0][sram_raddr_a0];
        sram_rdata_a1 <= mem[1][sram_raddr_a1];
        sram_rdata_a2 <= mem[2][sram_raddr_a2];
        sram_rdata_a3 <= mem[3][sram_raddr_a3];
    end

    // Record every change of any bank address.
    always @(negedge clk) begin
        logic [5:0] cur [4];
        cur[0] = sram_raddr_a0; cur[1] = sram_raddr_a1;
        cur[2] = sram_raddr_a2; cur[3] = sram_raddr_a3;
        for (int k = 0; k < 4; k++) begin
            if (rec_en && cur[k] !== prev_addr[k]) begin
                rec_bank.push_back(k);
                rec_addr.push_back(int'(cur[k]));
            end
            prev_addr[k] = cur[k];
        end
    end

    // Writer model straight from the layout formulas.
    task automatic fill(input bit neg);
        int br, bc, bank, addr, ir, ic, pos, ch, i;
        logic [11:0] v;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++) mem[b][a] = '0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                v = 12'(r * 28 + c);
                if (neg && r == 3 && c == 5) v = 12'hFF9;
                br = r / 4; bc = c / 4;
                bank = (br % 2) * 2 + (bc % 2);
                addr = (br / 2) * 4 + bc / 2;
                ir = r % 4; ic = c % 4;
                pos = (ir / 2) * 2 + ic / 2;
                ch = (ir % 2) * 2 + ic % 2;
                i = ch * 4 + pos;
                mem[bank][addr][(15 - i) * 12 +: 12] = v;
            end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Runs the stream from cycle 1 after the start cycle, recording observations only.
    task automatic collect(input bit rnd, input int abort_at, input int start_at);
        logic pv, pr, pl;
        logic [11:0] pd;
        pix.delete();
        npix = 0; first_vld = -1; last_cnt = 0; last_idx = -1; last_cyc = -1;
        done_cnt = 0; done_cyc = -1; stall_viol = 0; busy1 = 1'b0; busy_after = 1'b1;
        timeout = 1'b0;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        for (int cyc = 1; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (abort_at >= 0 && npix == abort_at) return;
            if (cyc == 1) busy1 = busy;
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) stall_viol++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                pix.push_back(out_data);
                if (out_last) begin last_cnt++; last_idx = npix; last_cyc = cyc; end
                npix++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (done_cyc >= 0 && cyc == done_cyc + 4) return;
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (cyc + 1 == start_at);
        end
        timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
        if (out_data !== 12'h0) begin errors++; $display("FAIL reset_data got %h want 000", out_data); end
        if ({sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3} !== 24'h0) begin
            errors++; $display("FAIL reset_raddr got %h/%h/%h/%h want 0", sram_raddr_a0,
                               sram_raddr_a1, sram_raddr_a2, sram_raddr_a3);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_ramp();
        int exp_b [$];
        int exp_a [$];
        int pe [4];
        int b, a;
        fill(1'b0);
        rec_bank.delete(); rec_addr.delete();
        rec_en = 1'b1;
        pulse_start();
        collect(1'b0, -1, -1);
        rec_en = 1'b0;
        checks++; if (timeout) begin errors++; $display("FAIL ramp_timeout got 1 want 0"); end
        checks++; if (npix != 784) begin errors++; $display("FAIL ramp_count got %0d want 784", npix); end
        for (int i = 0; i < pix.size(); i++) begin
            checks++;
            if (pix[i] !== 12'(i)) begin
                errors++; $display("FAIL ramp_seq idx %0d got %h want %h", i, pix[i], 12'(i)); break;
            end
        end
        checks++; if (first_vld != 3) begin errors++; $display("FAIL ramp_latency got %0d want 3", first_vld); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL ramp_busy got %b want 1", busy1); end
        checks++; if (last_cnt != 1 || last_idx != 783) begin
            errors++; $display("FAIL ramp_last got cnt %0d idx %0d want 1/783", last_cnt, last_idx);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ramp_done_cnt got %0d want 1", done_cnt); end
        checks++; if (done_cyc != last_cyc + 1) begin
            errors++; $display("FAIL ramp_done_time got %0d want %0d", done_cyc, last_cyc + 1);
        end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL ramp_idle_busy got %b want 0", busy_after); end
        // Expected address changes from the raster read order, starting from all-zero.
        for (int k = 0; k < 4; k++) pe[k] = 0;
        for (int r = 0; r < 28; r++)
            for (int bc = 0; bc < 7; bc++) begin
                b = ((r / 4) % 2) * 2 + (bc % 2);
                a = (r / 8) * 4 + bc / 2;
                if (a != pe[b]) begin exp_b.push_back(b); exp_a.push_back(a); end
                pe[b] = a;
            end
        checks++; if (rec_bank.size() != exp_b.size()) begin
            errors++; $display("FAIL addr_count got %0d want %0d", rec_bank.size(), exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < rec_bank.size(); i++) begin
            checks++;
            if (rec_bank[i] != exp_b[i] || rec_addr[i] != exp_a[i]) begin
                errors++; $display("FAIL addr_seq #%0d got a%0d@%0d want a%0d@%0d", i,
                                   rec_bank[i], rec_addr[i], exp_b[i], exp_a[i]);
                break;
            end
        end
    endtask

    task automatic test_backpressure();
        fill(1'b0);
        pulse_start();
        collect(1'b1, -1, -1);
        checks++; if (timeout) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
        checks++; if (npix != 784) begin errors++; $display("FAIL bp_count got %0d want 784", npix); end
        for (int i = 0; i < pix.size(); i++) begin
            checks++;
            if (pix[i] !== 12'(i)) begin
                errors++; $display("FAIL bp_seq idx %0d got %h want %h", i, pix[i], 12'(i)); break;
            end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_viol); end
        checks++; if (last_idx != 783 || done_cnt != 1) begin
            errors++; $display("FAIL bp_end got last %0d done %0d want 783/1", last_idx, done_cnt);
        end
    endtask

    task automatic test_negative();
        logic [11:0] exp_neg;
`ifdef UNSHUFFLE_READER_RELU_EN
        exp_neg = 12'h000;
`else
        exp_neg = 12'hFF9;
`endif
        fill(1'b1);
        pulse_start();
        collect(1'b0, -1, -1);
        checks++; if (npix != 784) begin errors++; $display("FAIL neg_count got %0d want 784", npix); end
        if (npix == 784) begin
            checks += 3;
            if (pix[89] !== exp_neg) begin errors++; $display("FAIL neg_pixel got %h want %h", pix[89], exp_neg); end
            if (pix[88] !== 12'd88) begin errors++; $display("FAIL neg_left got %h want %h", pix[88], 12'd88); end
            if (pix[90] !== 12'd90) begin errors++; $display("FAIL neg_right got %h want %h", pix[90], 12'd90); end
        end
    endtask

    task automatic test_reset_abort();
        int dn = 0;
        fill(1'b0);
        pulse_start();
        collect(1'b0, 300, -1);
        checks++; if (npix != 300 || out_valid !== 1'b1 || out_data !== 12'd300) begin
            errors++; $display("FAIL abort_pre got n %0d v %b d %h want 300/1/12c", npix, out_valid, out_data);
        end
        #1 rst = 1'b1;
        #1;
        checks += 3;
        if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", out_valid); end
        if ({sram_raddr_a0, sram_raddr_a1, sram_raddr_a2, sram_raddr_a3} !== 24'h0) begin
            errors++; $display("FAIL abort_raddr got nonzero want 0");
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) begin @(negedge clk); if (done) dn++; end
        checks++; if (dn != 0) begin errors++; $display("FAIL abort_done got %0d want 0", dn); end
        pulse_start();
        collect(1'b0, -1, -1);
        checks++; if (npix != 784 || done_cnt != 1) begin
            errors++; $display("FAIL replay_count got %0d/%0d want 784/1", npix, done_cnt);
        end
        for (int i = 0; i < pix.size(); i++) begin
            checks++;
            if (pix[i] !== 12'(i)) begin
                errors++; $display("FAIL replay_seq idx %0d got %h want %h", i, pix[i], 12'(i)); break;
            end
        end
    endtask

    task automatic test_back_to_back();
        fill(1'b0);
        pulse_start();
        collect(1'b0, -1, 100);
        checks++; if (npix != 784) begin errors++; $display("FAIL b2b_count got %0d want 784", npix); end
        checks++; if (done_cnt != 1 || last_idx != 783) begin
            errors++; $display("FAIL b2b_end got done %0d last %0d want 1/783", done_cnt, last_idx);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_restart got busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_negative();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
